// File: rtl/multdiv_issue.sv
// Issue/write-back controller for the iterative multiplier/divider: latches one
// MULT/DIV micro-op, pulses multdiv, stalls until the result, then writes it back.
module multdiv_issue #(
  parameter int TIMEOUT   = 48,
  parameter int MULT_CODE = 4,
  parameter int DIV_CODE  = 5,
  parameter int TO_CODE   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_is_div,
  input  logic [31:0] in_opA,
  input  logic [31:0] in_opB,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam logic [4:0] RSTATUS = 5'd30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  wait_cnt;
  logic        op_div;
  logic [4:0]  op_rd;

  function automatic logic [31:0] exc_code(input logic div);
    return div ? 32'(DIV_CODE) : 32'(MULT_CODE);
  endfunction

  // The completing op is still on in_valid during DONE, so only the state gates stall.
  assign stall = in_valid && (state != DONE) && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      op_div    <= 1'b0;
      op_rd     <= '0;
      md_opA    <= '0;
      md_opB    <= '0;
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      wb_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            md_opA    <= in_opA;
            md_opB    <= in_opB;
            op_rd     <= in_rd;
            op_div    <= in_is_div;
            ctrl_MULT <= !in_is_div;
            ctrl_DIV  <= in_is_div;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= flush ? IDLE : WAIT;
        end
        WAIT: begin
          if (flush) begin
            state <= IDLE;
          end else if (wait_cnt >= 6'(TIMEOUT)) begin
            wb_valid <= 1'b1;
            wb_rd    <= RSTATUS;
            wb_data  <= 32'(TO_CODE);
            state    <= DONE;
          end else if (wait_cnt >= 6'd2 && md_resultRDY) begin
            // RDY in the first two WAIT cycles may be left over from the previous op.
            wb_valid <= 1'b1;
            wb_rd    <= md_exception ? RSTATUS : op_rd;
            wb_data  <= md_exception ? exc_code(op_div) : md_result;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 6'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/multdiv_issue.md
# multdiv_issue

Issue/write-back controller sitting directly upstream of the iterative multiplier/divider (`multdiv`) in the execute stage. It accepts a MULT or DIV micro-op from the pipeline and latches its operands and destination. It then fires a single-cycle `ctrl_MULT`/`ctrl_DIV` pulse with the operands stable, stalls the pipeline until `data_resultRDY`, and returns one write-back beat. Overflow, divide-by-zero and timeout exceptions are mapped to `rstatus` (r30) writes.

## Interface
- `TIMEOUT`, 48: cycles in WAIT after which the op is abandoned (must exceed the 32-count divide).
- `MULT_CODE`, 4: `rstatus` value written on multiply overflow.
- `DIV_CODE`, 5: `rstatus` value written on divide by zero.
- `TO_CODE`, 6: `rstatus` value written on timeout.
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  execute stage holds a MULT/DIV micro-op; held high while `stall`=1.
- `in_is_div`  in  1  0 = multiply, 1 = divide.
- `in_opA`, `in_opB`  in  32  operands (A = multiplicand/dividend).
- `in_rd`  in  5  destination register.
- `flush`  in  1  squash the in-flight op (branch mispredict).
- `md_opA`, `md_opB`  out  32  to `data_operandA`/`data_operandB`.
- `ctrl_MULT`, `ctrl_DIV`  out  1  start pulses to `multdiv`.
- `md_result`  in  32  `data_result`.
- `md_exception`  in  1  `data_exception`.
- `md_resultRDY`  in  1  `data_resultRDY`.
- `stall`  out  1  freeze PC/F/D/X latches.
- `wb_valid`  out  1  one-cycle write-back strobe.
- `wb_rd`  out  5  write-back register.
- `wb_data`  out  32  write-back value.

## Operation
- States: IDLE, ISSUE, WAIT, DONE; 2-bit encoded; reset → IDLE.
- IDLE: if `in_valid` and not `flush`, capture `in_opA`/`in_opB`/`in_rd`/`in_is_div` into internal registers and go to ISSUE.
- ISSUE (exactly one cycle):
  - `md_opA`/`md_opB` drive the captured operands.
  - `ctrl_MULT`=~div, `ctrl_DIV`=div; the two are never high together.
  - Clear the wait counter; go to WAIT.
- WAIT:
  - Wait counter (6-bit) increments every cycle.
  - `md_resultRDY` is ignored while counter < 2, because stale RDY from the previous op can persist after the pulse.
  - First qualifying RDY: capture result/exception; go to DONE.
  - Counter reaching `TIMEOUT`: capture a timeout flag; go to DONE.
- DONE (one cycle): `wb_valid`=1; go to IDLE and ignore `in_valid` this cycle, since it still shows the completing op.
- Write-back values:
  - Normal completion: `wb_rd`=captured rd, `wb_data`=captured `md_result`.
  - Exception: `wb_rd`=30 and `wb_data`=zero-extended `MULT_CODE`/`DIV_CODE` by op type.
  - Timeout: `wb_rd`=30 and `wb_data`=`TO_CODE`; timeout takes priority over `md_exception`.
- `stall` = `in_valid` & (state≠DONE) & ~`flush`; combinational.
- `flush` in ISSUE/WAIT: go to IDLE next cycle with no `wb_valid`; the in-flight `multdiv` result is discarded.
- `flush` in DONE does not suppress `wb_valid`: the op has already committed.
- `md_opA`/`md_opB` hold their last captured values outside ISSUE; `ctrl_*` are 0 outside ISSUE.

## Timing
- Reset values: all outputs 0, state IDLE, captured registers 0.
- `reset` mid-op: immediate return to IDLE with outputs 0; `multdiv` is not re-pulsed.
- Cycle t: IDLE samples `in_valid`. t+1: ISSUE pulse. RDY first sampled at t+4.
- If RDY is first seen at cycle r, DONE and `wb_valid` occur at r+1, and `stall` drops at r+1.
- Multiply: RDY at count 16 → `wb_valid` ≈ t+19. Divide: count 32 → ≈ t+35.
- Back-to-back ops: the next op is sampled in IDLE at r+2, giving a minimum one-cycle bubble between a DONE and the next ISSUE.
- `ctrl_*` are registered outputs (no combinational path from `in_valid`).

## Test plan
- MULT 7×(−3), rd=5: one `ctrl_MULT` pulse at t+1 with `md_opA`=7, `md_opB`=0xFFFFFFFD. Expect `wb_valid` once with rd=5, data=0xFFFFFFEB, `stall` high until DONE.
- DIV −20÷6, rd=9: one `ctrl_DIV` pulse. Expect `wb_valid` with rd=9, data=0xFFFFFFFD, and no `ctrl_MULT` at any time.
- DIV 1÷0: `md_exception`=1 at RDY. Expect rd=30, data=5.
- MULT 0x7FFFFFFF×2: exception. Expect rd=30, data=4.
- Stale-RDY and timeout:
  - Hold `md_resultRDY`=1 through the ISSUE cycle and the next cycle, then drop it: no early completion.
  - Never raise RDY again: at WAIT count 48 expect rd=30, data=6.
- `flush` at WAIT cycle 5: no `wb_valid`, IDLE next cycle. A following MULT 3×4 writes 12 correctly.
- `reset` pulsed mid-WAIT: all outputs 0 immediately, no write-back.
